// File: rtl/add_round_key_serial_pkg.sv
// add_round_key_serial_pkg: shared AES types, constants and byte-lane mapping
package add_round_key_serial_pkg;

   localparam int AES_STATE_BYTES = 16;

   typedef enum logic {COLLECT, HOLD} ark_state_e;

   typedef enum logic [1:0] {ROW1, ROW2, ROW3, ROW4} row_index_e;

   function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
      return 7'd120 - {idx, 3'b000};
   endfunction

endpackage

// File: rtl/add_round_key_serial.sv
// add_round_key_serial: byte-serial AES AddRoundKey producing a registered 128-bit keyed block
module add_round_key_serial
   import add_round_key_serial_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_byte,
   input  logic [127:0] round_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic [3:0]   byte_cnt
);

   ark_state_e   state, state_nx;
   logic [127:0] key_q, res_q;
   logic [6:0]   lsb;
   logic [7:0]   key_byte;
   logic         accept, last;

   assign lsb       = byte_lsb(byte_cnt);
   assign accept    = in_valid && in_ready;
   assign last      = byte_cnt == 4'(AES_STATE_BYTES - 1);
   assign key_byte  = byte_cnt == 4'd0 ? round_key[lsb +: 8] : key_q[lsb +: 8];
   assign in_ready  = state == COLLECT;
   assign out_valid = state == HOLD;
   assign out_state = res_q;

   // collect until byte 15 lands, then hold the block until the consumer takes it
   always_comb begin
      state_nx = state == COLLECT ? (accept && last ? HOLD : COLLECT)
                                  : (out_ready ? COLLECT : HOLD);
   end

   // state, byte index, latched key and keyed result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= COLLECT;
         byte_cnt <= 4'd0;
         key_q    <= 128'h0;
         res_q    <= 128'h0;
      end else begin
         state <= state_nx;
         if (accept) begin
            res_q[lsb +: 8] <= in_byte ^ key_byte;
            byte_cnt        <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd0) key_q <= round_key;
         end
      end
   end

endmodule

// File: tb/tb_add_round_key_serial.sv
// tb_add_round_key_serial: scoreboard bench for the byte-serial AddRoundKey block
module tb_add_round_key_serial;

   localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_byte = 8'h0;
   logic [127:0] round_key = 128'h0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_state;
   logic [3:0]   byte_cnt;

   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           last_hs = -1;
   logic         b2b = 1'b0;
   logic [127:0] exp_q[$];

   add_round_key_serial dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
      .round_key(round_key), .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .byte_cnt(byte_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_byte  = b;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: byte %h not accepted within 100 cycles", b);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // chg: 0 key steady, 1 key forced to all ones after byte 0, 2 key scrambled after every byte
   task automatic send_block(input logic [127:0] blk, input logic [127:0] key,
                             input int chg, input int maxgap);
      exp_q.push_back(blk ^ key);
      round_key = key;
      for (int i = 0; i < 16; i++) begin
         int g = maxgap > 0 ? $urandom_range(maxgap, 0) : 0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         send_byte(blk[127-8*i -: 8]);
         if (chg == 1 && i == 0) round_key = '1;
         if (chg == 2) round_key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      check("latency_out_valid", 128'(out_valid), 128'd1);
   endtask

   // monitor: every completed output handshake is checked against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got %h, expected none", out_state);
            end else begin
               check("out_state", out_state, exp_q.pop_front());
            end
            if (b2b) begin
               if (last_hs >= 0) check("b2b_period", 128'(cyc - last_hs), 128'd17);
               last_hs = cyc;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [127:0] blk;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 128'(in_ready), 128'd1);
      check("reset_out_valid", 128'(out_valid), 128'd0);
      check("reset_byte_cnt", 128'(byte_cnt), 128'd0);
      check("reset_out_state", out_state, 128'h0);
      @(posedge clk);
      #1;

      send_block(FIPS_IN, FIPS_KEY, 0, 0);
      check("fips_model", FIPS_IN ^ FIPS_KEY, FIPS_OUT);
      send_block(128'h0, SEQ_KEY, 0, 0);
      send_block(FIPS_IN, FIPS_KEY, 1, 0);
      send_block(FIPS_IN, FIPS_KEY, 0, 3);

      @(posedge clk);
      #1 out_ready = 1'b0;
      send_block(FIPS_IN, FIPS_KEY, 0, 0);
      in_valid = 1'b1;
      in_byte  = 8'h5a;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_in_ready", 128'(in_ready), 128'd0);
         check("stall_out_valid", 128'(out_valid), 128'd1);
         check("stall_out_state", out_state, FIPS_OUT);
         check("stall_byte_cnt", 128'(byte_cnt), 128'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;

      round_key = FIPS_KEY;
      for (int i = 0; i < 8; i++) send_byte(8'($urandom));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_byte_cnt", 128'(byte_cnt), 128'd0);
      check("abort_out_valid", 128'(out_valid), 128'd0);
      check("abort_in_ready", 128'(in_ready), 128'd1);
      check("abort_out_state", out_state, 128'h0);
      @(posedge clk);
      #1;
      send_block(FIPS_IN, FIPS_KEY, 0, 0);

      @(posedge clk);
      #1 last_hs = -1;
      b2b = 1'b1;
      for (int k = 0; k < 5; k++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         send_block(blk, {$urandom, $urandom, $urandom, $urandom}, 2, 0);
      end
      @(posedge clk);
      #1 b2b = 1'b0;

      for (int k = 0; k < 6; k++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         send_block(blk, {$urandom, $urandom, $urandom, $urandom}, 2, 4);
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/add_round_key_serial.md
ADD_ROUND_KEY_SERIAL -- requirements
Module: add_round_key_serial

Interface
REQ-001 The block SHALL have no parameters; the state is fixed at 16 bytes, 128 bits.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  a MixColumns result byte is presented on in_byte.
REQ-005 in_ready  output  1  the block can accept a byte this cycle.
REQ-006 in_byte  input  8  state byte in column-major order: index i is column i/4, row i%4, which matches the row_index sequencing of the MixColumns stage.
REQ-007 round_key  input  128  round key; byte i is round_key[127-8i -: 8].
REQ-008 out_valid  output  1  out_state holds a complete keyed block.
REQ-009 out_ready  input  1  the downstream consumer accepts out_state.
REQ-010 out_state  output  128  keyed state; byte i is out_state[127-8i -: 8].
REQ-011 byte_cnt  output  4  index of the next byte to be accepted.

Function
REQ-012 A byte SHALL transfer when in_valid and in_ready are both high on a rising edge of clk.
REQ-013 The FSM SHALL have two states: COLLECT, with in_ready=1 and out_valid=0, and HOLD, with in_ready=0 and out_valid=1.
REQ-014 In COLLECT, each accepted byte SHALL be XORed with key byte byte_cnt and written to result byte byte_cnt, and byte_cnt SHALL then increment.
REQ-015 On acceptance of byte 0, round_key SHALL be latched into an internal key register.
REQ-016 Byte 0 SHALL use round_key directly; bytes 1..15 SHALL use the latched key, so changes on round_key mid-block have no effect.
REQ-017 Accepting byte 15 SHALL move the FSM to HOLD and wrap byte_cnt to 0.
REQ-018 out_valid SHALL rise on the cycle after byte 15 is accepted, giving a latency of 1 cycle from the last byte.
REQ-019 In HOLD, out_state SHALL remain stable until the handshake completes.
REQ-020 out_valid and out_state SHALL NOT depend combinationally on out_ready.
REQ-021 In HOLD, out_valid && out_ready SHALL return the FSM to COLLECT on the next edge.
REQ-022 A new byte 0 SHALL be acceptable on the cycle after that return, giving a sustained throughput of 17 cycles per block.
REQ-023 in_valid asserted while in HOLD SHALL be ignored; no byte is consumed.
REQ-024 in_valid deasserted mid-block SHALL stall the block: byte_cnt and the partial result hold, with no timeout.
REQ-025 The XOR SHALL be pure bitwise GF(2) addition with no carry or width extension.
REQ-026 out_state SHALL be driven from a register and never from a combinational XOR path.

Reset
REQ-027 rst high on a rising edge SHALL force state=COLLECT, byte_cnt=0, out_valid=0, in_ready=1, the result register to 128'h0 and the key register to 128'h0.
REQ-028 Reset SHALL take priority over any simultaneous handshake.
REQ-029 A block in progress or in HOLD when rst asserts SHALL be discarded, not completed.
REQ-030 On the first cycle after rst deasserts, in_ready SHALL be 1.

Structure
REQ-031 The shared AES package SHALL hold the FSM state encoding (COLLECT, HOLD), the constant AES_STATE_BYTES=16, and the byte-index-to-bit-slice mapping function.
REQ-032 The existing MixColumns row encodings ROW1..ROW4 SHALL move to the same package.
REQ-033 The block SHALL be a single module with no sub-modules.
REQ-034 The byte-lane XOR SHALL be one indexed expression, not 16 instances.

Verification
REQ-035 FIPS-197 round 1: feed bytes of 046681e5e0cb199a48f8d37a2806264c with round_key=a0fafe1788542cb123a339392a6c7605 -> out_state=a49c7ff2689f352b6b5bea43026a5049, out_valid high exactly 1 cycle after byte 15.
REQ-036 All-zero state with round_key=000102030405060708090a0b0c0d0e0f -> out_state=000102030405060708090a0b0c0d0e0f.
REQ-037 Change round_key to ffff...ff after byte 0 of the REQ-035 vector -> output still a49c7ff2689f352b6b5bea43026a5049.
REQ-038 Hold out_ready=0 for 10 cycles with in_valid held high -> in_ready=0 throughout, out_state stable, no byte consumed, byte_cnt=0.
REQ-039 Random in_valid gaps inserted between bytes -> result identical to REQ-035.
REQ-040 Back-to-back blocks with out_ready=1 -> a new out_valid every 17 cycles.
REQ-041 Assert rst after byte 7 -> byte_cnt=0 and out_valid=0; the next full block yields the correct result with no residue from the aborted block.
